lut1_sweep_ctrl: RTL and testbench

//  Self-checking sequencer for the 12-output CC_LUT1 bank used in the LUT1 verification tops.
//  - Outputs 0..3: four LUTs with INIT=0..3, each driven by i[idx].
//  - Outputs 4..11: constant-input LUTs.

---
 rtl/lut1_sweep_if.sv | 29 ++
 rtl/lut1_sweep_ctrl.sv | 105 ++++++++++
 tb/tb_lut1_sweep_ctrl.sv | 196 +++++++++++++++++++
 3 files changed

// File: rtl/lut1_sweep_if.sv
// lut1_sweep_if: control/status and LUT-bank stimulus bus of the LUT1 sweep sequencer.
// LUT1_SWEEP_FIRSTFAIL_EN adds the first-failure capture signals.
interface lut1_sweep_if;
    logic        start;
    logic        abort;
    logic        busy;
    logic        done;
    logic        pass;
    logic [3:0]  dut_i;
    logic [11:0] dut_o;
    logic [7:0]  err_count;
    logic [11:0] fail_vec;
`ifdef LUT1_SWEEP_FIRSTFAIL_EN
    logic        first_fail_valid;
    logic [3:0]  first_fail_vec;
    logic [11:0] first_fail_obs;
    modport master (input start, abort, dut_o,
                    output dut_i, busy, done, pass, err_count, fail_vec,
                    output first_fail_valid, first_fail_vec, first_fail_obs);
    modport slave  (output start, abort, dut_o,
                    input dut_i, busy, done, pass, err_count, fail_vec,
                    input first_fail_valid, first_fail_vec, first_fail_obs);
`else
    modport master (input start, abort, dut_o,
                    output dut_i, busy, done, pass, err_count, fail_vec);
    modport slave  (output start, abort, dut_o,
                    input dut_i, busy, done, pass, err_count, fail_vec);
`endif
endinterface

// File: rtl/lut1_sweep_ctrl.sv
// lut1_sweep_ctrl: sweeps all 4-bit vectors through the 12-output LUT1 bank and checks the results.
// LUT1_SWEEP_FIRSTFAIL_EN adds capture of the first mismatching vector and observation.
module lut1_sweep_ctrl #(
    parameter int SETTLE_CYCLES = 2,
    parameter int N_PASSES      = 1
) (
    input  logic clk,
    input  logic rst_n,
    lut1_sweep_if.master bus
);
    typedef enum logic [2:0] {IDLE, DRIVE, SETTLE, CHECK, DONE} state_t;
    localparam int SW = $clog2(SETTLE_CYCLES + 2);

    state_t        state, state_nx;
    logic [SW-1:0] settle_cnt;
    logic [3:0]    vec;
    logic [7:0]    pass_cnt;
    logic [11:0]   exp_o, mism;
    logic          last, settle_done;

    always_ff @(posedge clk)
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;

    always_comb begin
        state_nx = state;
        if (bus.abort) state_nx = IDLE;
        else
            case (state)
                IDLE:    state_nx = bus.start ? DRIVE : IDLE;
                DRIVE:   state_nx = (SETTLE_CYCLES > 0) ? SETTLE : CHECK;
                SETTLE:  state_nx = settle_done ? CHECK : SETTLE;
                CHECK:   state_nx = last ? DONE : DRIVE;
                default: state_nx = IDLE;
            endcase
    end

    // Bank truth: LUT k (INIT=k) on i[k] for outputs 0..3, fixed pattern above.
    always_comb begin
        bus.busy    = state inside {DRIVE, SETTLE, CHECK};
        exp_o       = {8'hE4, 1'b1, bus.dut_i[2], ~bus.dut_i[1], 1'b0};
        mism        = bus.dut_o ^ exp_o;
        last        = vec == 4'hF && pass_cnt == 8'(N_PASSES - 1);
        settle_done = settle_cnt == SW'(SETTLE_CYCLES - 1);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            bus.dut_i     <= '0;
            bus.done      <= 1'b0;
            bus.pass      <= 1'b0;
            bus.err_count <= '0;
            bus.fail_vec  <= '0;
            vec           <= '0;
            pass_cnt      <= '0;
            settle_cnt    <= '0;
        end else if (bus.abort) begin
            bus.dut_i <= '0;
            bus.done  <= 1'b0;
            bus.pass  <= 1'b0;
        end else
            case (state)
                IDLE: if (bus.start) begin
                    bus.done      <= 1'b0;
                    bus.pass      <= 1'b0;
                    bus.err_count <= '0;
                    bus.fail_vec  <= '0;
                    vec           <= '0;
                    pass_cnt      <= '0;
                end
                DRIVE: begin
                    bus.dut_i  <= vec;
                    settle_cnt <= '0;
                end
                SETTLE: settle_cnt <= settle_cnt + 1'b1;
                CHECK: begin
                    bus.fail_vec <= bus.fail_vec | mism;
                    if (|mism && bus.err_count != 8'hFF) bus.err_count <= bus.err_count + 8'd1;
                    if (!last) begin
                        vec <= vec + 4'd1;
                        if (vec == 4'hF) pass_cnt <= pass_cnt + 8'd1;
                    end
                end
                DONE: begin
                    bus.done <= 1'b1;
                    bus.pass <= bus.err_count == 8'd0;
                end
                default: ;
            endcase
    end

`ifdef LUT1_SWEEP_FIRSTFAIL_EN
    always_ff @(posedge clk) begin
        if (!rst_n || (!bus.abort && state == IDLE && bus.start)) begin
            bus.first_fail_valid <= 1'b0;
            bus.first_fail_vec   <= '0;
            bus.first_fail_obs   <= '0;
        end else if (!bus.abort && state == CHECK && |mism && !bus.first_fail_valid) begin
            bus.first_fail_valid <= 1'b1;
            bus.first_fail_vec   <= bus.dut_i;
            bus.first_fail_obs   <= bus.dut_o;
        end
    end
`endif
endmodule

// File: tb/tb_lut1_sweep_ctrl.sv
// tb_lut1_sweep_ctrl: directed bench for lut1_sweep_ctrl with a behavioural LUT1 bank and fault injection.
// Honours LUT1_SWEEP_FIRSTFAIL_EN for the first-failure outputs.
module tb_lut1_sweep_ctrl;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;
    int   fault = 0;
    int   nxt, bad, n;
    logic trk = 1'b0;

    always #5 clk = ~clk;

    lut1_sweep_if if0 ();
    lut1_sweep_if if1 ();
    lut1_sweep_if if2 ();

    lut1_sweep_ctrl #(.SETTLE_CYCLES(2), .N_PASSES(1))  u0 (.clk(clk), .rst_n(rst_n), .bus(if0));
    lut1_sweep_ctrl #(.SETTLE_CYCLES(0), .N_PASSES(3))  u1 (.clk(clk), .rst_n(rst_n), .bus(if1));
    lut1_sweep_ctrl #(.SETTLE_CYCLES(2), .N_PASSES(20)) u2 (.clk(clk), .rst_n(rst_n), .bus(if2));

    function automatic logic lut1(input logic [1:0] init, input logic x);
        return init[x];
    endfunction

    // 1: o[3] stuck 0, 2: o[5] high at v=A, 3: o[0] stuck 1
    function automatic logic [11:0] bank(input logic [3:0] v);
        logic [11:0] o;
        o[0] = lut1(2'd0, v[0]);
        o[1] = lut1(2'd1, v[1]);
        o[2] = lut1(2'd2, v[2]);
        o[3] = lut1(2'd3, v[3]);
        o[11:4] = 8'b1110_0100;
        if (fault == 1) o[3] = 1'b0;
        if (fault == 2 && v == 4'hA) o[5] = 1'b1;
        if (fault == 3) o[0] = 1'b1;
        return o;
    endfunction

    assign if0.dut_o = bank(if0.dut_i);
    assign if1.dut_o = bank(if1.dut_i);
    assign if2.dut_o = bank(if2.dut_i);

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    function automatic logic done_of(input int w);
        return w == 0 ? if0.done : (w == 1 ? if1.done : if2.done);
    endfunction

    task automatic pulse(input int w);
        if (w == 0) if0.start = 1'b1; else if (w == 1) if1.start = 1'b1; else if2.start = 1'b1;
        @(posedge clk);
        #1;
        if0.start = 1'b0;
        if1.start = 1'b0;
        if2.start = 1'b0;
    endtask

    task automatic wait_done(input int w, input int budget, output int cyc);
        cyc = -1;
        for (int c = 1; c <= budget; c++) begin
            @(posedge clk);
            #1;
            if (trk) begin
                if (if0.dut_i == nxt[3:0] && nxt < 16) nxt++;
                else if (!(nxt > 0 && if0.dut_i == 4'(nxt - 1))) bad++;
            end
            if (done_of(w)) begin
                cyc = c;
                break;
            end
        end
    endtask

    initial begin
        {if0.start, if0.abort, if1.start, if1.abort, if2.start, if2.abort} = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_dut_i", 32'(if0.dut_i), 0);
        chk("rst_busy", 32'(if0.busy), 0);
        chk("rst_done", 32'(if0.done), 0);
        chk("rst_pass", 32'(if0.pass), 0);
        chk("rst_err", 32'(if0.err_count), 0);
        chk("rst_fail_vec", 32'(if0.fail_vec), 0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // ideal sweep, vectors in order
        nxt = 0; bad = 0; trk = 1'b1;
        pulse(0);
        chk("t1_busy", 32'(if0.busy), 1);
        wait_done(0, 200, n);
        trk = 1'b0;
        chk("t1_latency", 32'(n), 65);
        chk("t1_pass", 32'(if0.pass), 1);
        chk("t1_err", 32'(if0.err_count), 0);
        chk("t1_fail_vec", 32'(if0.fail_vec), 0);
        chk("t1_busy_done", 32'(if0.busy), 0);
        chk("t1_seq_count", 32'(nxt), 16);
        chk("t1_seq_order", 32'(bad), 0);
        @(posedge clk);
        #1;
        chk("t1_done_held", 32'(if0.done), 1);

        fault = 1;
        pulse(0);
        chk("t2_done_clr", 32'(if0.done), 0);
        wait_done(0, 200, n);
        chk("t2_err", 32'(if0.err_count), 16);
        chk("t2_fail_vec", 32'(if0.fail_vec), 32'h008);
        chk("t2_pass", 32'(if0.pass), 0);

        fault = 2;
        pulse(0);
        wait_done(0, 200, n);
        chk("t3_err", 32'(if0.err_count), 1);
        chk("t3_fail_vec", 32'(if0.fail_vec), 32'h020);
        chk("t3_pass", 32'(if0.pass), 0);
`ifdef LUT1_SWEEP_FIRSTFAIL_EN
        chk("t3_ff_valid", 32'(if0.first_fail_valid), 1);
        chk("t3_ff_vec", 32'(if0.first_fail_vec), 32'hA);
        chk("t3_ff_obs", 32'(if0.first_fail_obs), 32'hE68);
`endif

        // three passes, zero settle, starts while busy ignored
        fault = 0;
        pulse(1);
        n = -1;
        for (int c = 1; c <= 200; c++) begin
            if1.start = (c == 10 || c == 50);
            @(posedge clk);
            #1;
            if (if1.done) begin
                n = c;
                break;
            end
        end
        if1.start = 1'b0;
        chk("t4_latency", 32'(n), 97);
        chk("t4_err", 32'(if1.err_count), 0);
        chk("t4_pass", 32'(if1.pass), 1);

        // abort mid-sweep
        pulse(0);
        repeat (19) @(posedge clk);
        #1;
        chk("t5_busy_pre", 32'(if0.busy), 1);
        if0.abort = 1'b1;
        @(posedge clk);
        #1;
        if0.abort = 1'b0;
        chk("t5_busy", 32'(if0.busy), 0);
        chk("t5_done", 32'(if0.done), 0);
        chk("t5_dut_i", 32'(if0.dut_i), 0);
        repeat (3) @(posedge clk);
        #1;
        chk("t5_idle", 32'(if0.busy), 0);
        pulse(0);
        wait_done(0, 200, n);
        chk("t5_restart_latency", 32'(n), 65);
        chk("t5_restart_pass", 32'(if0.pass), 1);

        // reset mid-sweep, then saturation
        fault = 3;
        pulse(2);
        repeat (30) @(posedge clk);
        #1;
        chk("t6_err_mid", 32'(if2.err_count), 7);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        chk("t6_rst_busy", 32'(if2.busy), 0);
        chk("t6_rst_done", 32'(if2.done), 0);
        chk("t6_rst_pass", 32'(if2.pass), 0);
        chk("t6_rst_err", 32'(if2.err_count), 0);
        chk("t6_rst_fail_vec", 32'(if2.fail_vec), 0);
        chk("t6_rst_dut_i", 32'(if2.dut_i), 0);
        pulse(2);
        wait_done(2, 1500, n);
        chk("t6_latency", 32'(n), 1281);
        chk("t6_err_sat", 32'(if2.err_count), 255);
        chk("t6_fail_vec", 32'(if2.fail_vec), 32'h001);
        chk("t6_pass", 32'(if2.pass), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
